// File: rtl/uart_tx_scheduler_if.sv
// Wishbone master/slave bundle between the TX scheduler and the UART register port.
interface uart_tx_scheduler_if;
   logic [2:0] M_WB_ADRo;
   logic [7:0] M_WB_DATo;
   logic [7:0] M_WB_DATi;
   logic       M_WB_WEo;
   logic       M_WB_CYCo;
   logic       M_WB_STBo;
   logic       M_WB_ACKi;

   modport master (
      output M_WB_ADRo, M_WB_DATo, M_WB_WEo, M_WB_CYCo, M_WB_STBo,
      input  M_WB_DATi, M_WB_ACKi
   );

   modport slave (
      input  M_WB_ADRo, M_WB_DATo, M_WB_WEo, M_WB_CYCo, M_WB_STBo,
      output M_WB_DATi, M_WB_ACKi
   );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Shares one UART among NREQ byte sources: programs the baud divisor, then
// grants requesters round-robin and runs TDATA write / start / Tx_done poll per byte.
//
// state    | meaning
// S_INIT_L | write BDRL with divisor low byte
// S_INIT_H | write BDRH with divisor high byte
// S_IDLE   | wait for any request, pick next one round-robin
// S_WR_DAT | write granted byte to TDATA
// S_WR_GO  | write start bit to STATE
// S_POLL   | read STATE until Tx_done or poll budget exhausted
// S_FIN    | one-cycle done/err pulse, advance round-robin pointer
module uart_tx_scheduler #(
   parameter int              NREQ     = 4,
   parameter logic [15:0]     BDR_INIT = 16'h1458,
   parameter int              TO_W     = 20,
   parameter logic [TO_W-1:0] TIMEOUT  = 20'hFFFFF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [8*NREQ-1:0]    req_data,
   output logic [NREQ-1:0]      done,
   output logic                 err,
   output logic                 busy,
   uart_tx_scheduler_if.master  m_wb
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [2:0] A_STATE = 3'd0;
   localparam logic [2:0] A_TDATA = 3'd2;
   localparam logic [2:0] A_BDRL  = 3'd3;
   localparam logic [2:0] A_BDRH  = 3'd4;

   typedef enum logic [2:0] {
      S_INIT_L, S_INIT_H, S_IDLE, S_WR_DAT, S_WR_GO, S_POLL, S_FIN
   } state_t;

   state_t            r_state;
   logic [IW-1:0]     r_rr_ptr;
   logic [IW-1:0]     r_idx;
   logic [7:0]        r_byte;
   logic [TO_W-1:0]   r_to_cnt;
   logic              r_stb;
   logic              r_we;
   logic [2:0]        r_adr;
   logic [7:0]        r_dat;
   logic [NREQ-1:0]   r_done;
   logic              r_err;
   logic              r_busy;

   logic              w_ack;
   logic              w_found;
   logic [IW-1:0]     w_gidx;
   logic [7:0]        w_gbyte;
   int                w_j;

   assign w_ack = r_stb & m_wb.M_WB_ACKi;

   // Scan from the highest offset down so the lowest offset from rr_ptr wins.
   always_comb begin
      w_found = 1'b0;
      w_gidx  = '0;
      w_j     = 0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         w_j = (int'(r_rr_ptr) + i) % NREQ;
         if (req[w_j]) begin
            w_found = 1'b1;
            w_gidx  = IW'(w_j);
         end
      end
   end

   assign w_gbyte = req_data[8*w_gidx +: 8];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_INIT_L;
         r_rr_ptr <= '0;
         r_idx    <= '0;
         r_byte   <= '0;
         r_to_cnt <= '0;
         r_stb    <= 1'b0;
         r_we     <= 1'b0;
         r_adr    <= '0;
         r_dat    <= '0;
         r_done   <= '0;
         r_err    <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_done <= '0;
         r_err  <= 1'b0;
         case (r_state)
            S_INIT_L: begin
               r_busy <= 1'b1;
               if (!r_stb) begin
                  r_stb <= 1'b1;
                  r_we  <= 1'b1;
                  r_adr <= A_BDRL;
                  r_dat <= BDR_INIT[7:0];
               end else if (w_ack) begin
                  r_stb   <= 1'b0;
                  r_state <= S_INIT_H;
               end
            end
            S_INIT_H: begin
               if (!r_stb) begin
                  r_stb <= 1'b1;
                  r_we  <= 1'b1;
                  r_adr <= A_BDRH;
                  r_dat <= BDR_INIT[15:8];
               end else if (w_ack) begin
                  r_stb   <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            S_IDLE: begin
               if (w_found) begin
                  r_idx   <= w_gidx;
                  r_byte  <= w_gbyte;
                  r_busy  <= 1'b1;
                  r_state <= S_WR_DAT;
               end
            end
            S_WR_DAT: begin
               if (!r_stb) begin
                  r_stb <= 1'b1;
                  r_we  <= 1'b1;
                  r_adr <= A_TDATA;
                  r_dat <= r_byte;
               end else if (w_ack) begin
                  r_stb   <= 1'b0;
                  r_state <= S_WR_GO;
               end
            end
            S_WR_GO: begin
               if (!r_stb) begin
                  r_stb <= 1'b1;
                  r_we  <= 1'b1;
                  r_adr <= A_STATE;
                  r_dat <= 8'h01;
               end else if (w_ack) begin
                  r_stb    <= 1'b0;
                  r_to_cnt <= '0;
                  r_state  <= S_POLL;
               end
            end
            S_POLL: begin
               if (!r_stb) begin
                  r_stb <= 1'b1;
                  r_we  <= 1'b0;
                  r_adr <= A_STATE;
               end else if (w_ack) begin
                  r_stb <= 1'b0;
                  // Tx_done wins over the budget check on the final read.
                  if (m_wb.M_WB_DATi[4]) begin
                     r_done  <= {{(NREQ-1){1'b0}}, 1'b1} << r_idx;
                     r_state <= S_FIN;
                  end else if (r_to_cnt == TIMEOUT - 1'b1) begin
                     r_done  <= {{(NREQ-1){1'b0}}, 1'b1} << r_idx;
                     r_err   <= 1'b1;
                     r_state <= S_FIN;
                  end else begin
                     r_to_cnt <= r_to_cnt + 1'b1;
                  end
               end
            end
            S_FIN: begin
               r_rr_ptr <= (r_idx == IW'(NREQ - 1)) ? '0 : r_idx + 1'b1;
               r_busy   <= 1'b0;
               r_state  <= S_IDLE;
            end
            default: begin
               r_stb   <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign m_wb.M_WB_CYCo = r_stb;
   assign m_wb.M_WB_STBo = r_stb;
   assign m_wb.M_WB_WEo  = r_we;
   assign m_wb.M_WB_ADRo = r_adr;
   assign m_wb.M_WB_DATo = r_dat;
   assign done           = r_done;
   assign err            = r_err;
   assign busy           = r_busy;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a behavioural UART slave and
// write/done scoreboards filled by the stimulus and drained by a bus monitor.
module tb_uart_tx_scheduler;

   typedef struct {
      int idx;
      bit e;
      int reads;
   } done_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req = '0;
   logic [31:0] req_data = 32'h44332211;
   logic [3:0]  done;
   logic        err;
   logic        busy;

   int  n_tests = 0;
   int  n_fail  = 0;
   int  mon_reads = 0;
   int  ack_delay = 0;
   int  ready_after = 0;
   bit  never_ready = 1'b0;
   int  wcnt = 0;
   int  srd = 0;

   logic [10:0] exp_wr[$];
   done_t       exp_done[$];

   always #5 clk = ~clk;

   uart_tx_scheduler_if bus();

   uart_tx_scheduler #(
      .NREQ(4), .BDR_INIT(16'h1458), .TO_W(20), .TIMEOUT(20'd16)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data),
      .done(done), .err(err), .busy(busy), .m_wb(bus)
   );

   // UART slave: ACK after ack_delay wait cycles, Tx_done after ready_after reads.
   always @(posedge clk) begin
      if (!bus.M_WB_STBo || bus.M_WB_ACKi) wcnt <= 0;
      else wcnt <= wcnt + 1;
      if (bus.M_WB_STBo && bus.M_WB_ACKi && bus.M_WB_ADRo == 3'd0)
         srd <= bus.M_WB_WEo ? 0 : srd + 1;
   end

   assign bus.M_WB_ACKi = bus.M_WB_STBo && (wcnt >= ack_delay);
   assign bus.M_WB_DATi = (!never_ready && srd >= ready_after) ? 8'h10 : 8'hEF;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_byte(input int idx, input logic [7:0] b, input bit e, input int reads);
      done_t d;
      exp_wr.push_back({3'd2, b});
      exp_wr.push_back({3'd0, 8'h01});
      d.idx = idx; d.e = e; d.reads = reads;
      exp_done.push_back(d);
   endtask

   task automatic init_seq();
      exp_wr.push_back({3'd3, 8'h58});
      exp_wr.push_back({3'd4, 8'h14});
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      chk("init_busy", busy, 0);
      chk("init_writes_left", exp_wr.size(), 0);
   endtask

   task automatic wait_done(input int max, input string tag, output int k);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (done == 0 && k < max);
      if (done == 0) chk({tag, "_timeout"}, done != 0, 1);
   endtask

   // Monitor: drains the scoreboards and checks bus stability while pending.
   initial begin
      logic        pend;
      logic [11:0] prev;
      logic [10:0] e;
      done_t       d;
      pend = 1'b0;
      prev = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            pend = 1'b0;
            mon_reads = 0;
         end else begin
            if (pend && bus.M_WB_STBo)
               chk("bus_stable", {bus.M_WB_WEo, bus.M_WB_ADRo, bus.M_WB_DATo}, prev);
            pend = bus.M_WB_STBo && !bus.M_WB_ACKi;
            prev = {bus.M_WB_WEo, bus.M_WB_ADRo, bus.M_WB_DATo};
            if (bus.M_WB_STBo && bus.M_WB_ACKi) begin
               if (bus.M_WB_WEo) begin
                  if (exp_wr.size() == 0) chk("wr_unexpected", exp_wr.size(), 1);
                  else begin
                     e = exp_wr.pop_front();
                     chk("wr", {bus.M_WB_ADRo, bus.M_WB_DATo}, e);
                  end
               end else begin
                  chk("rd_adr", bus.M_WB_ADRo, 0);
                  mon_reads++;
               end
            end
            chk("done_onehot", $onehot0(done), 1);
            if (done != 0) begin
               if (exp_done.size() == 0) chk("done_unexpected", done, 0);
               else begin
                  d = exp_done.pop_front();
                  chk("done_vec", done, 32'd1 << d.idx);
                  chk("done_err", err, d.e);
                  chk("poll_reads", mon_reads, d.reads);
               end
               mon_reads = 0;
            end else begin
               chk("err_idle", err, 0);
            end
         end
      end
   end

   initial begin
      int k;
      repeat (2) @(negedge clk);
      chk("rst_cyc", bus.M_WB_CYCo, 0);
      chk("rst_stb", bus.M_WB_STBo, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_busy", busy, 0);
      init_seq();

      // single byte, Tx_done on 4th read
      req_data = 32'h443322A5;
      ready_after = 3;
      push_byte(0, 8'hA5, 1'b0, 4);
      req = 4'b0001;
      wait_done(100, "single", k);
      req = 4'b0000;
      chk("latency_min", k >= 8, 1);
      repeat (3) @(negedge clk);

      // all requesters held, from a fresh reset: order 0,1,2,3,0
      rst = 1'b1;
      @(negedge clk);
      init_seq();
      req_data = 32'h44332211;
      ready_after = 0;
      for (int i = 0; i < 5; i++) push_byte(i % 4, req_data[8*(i%4) +: 8], 1'b0, 1);
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         wait_done(100, "rr", k);
         chk("rr_busy_in_fin", busy, 1);
      end
      req = 4'b0000;
      repeat (3) @(negedge clk);
      chk("rr_drained", exp_done.size(), 0);

      // timeout on requester 1, then requester 2 served normally
      never_ready = 1'b1;
      push_byte(1, 8'h22, 1'b1, 16);
      push_byte(2, 8'h33, 1'b0, 1);
      req = 4'b0110;
      wait_done(200, "timeout", k);
      never_ready = 1'b0;
      req = 4'b0100;
      wait_done(100, "after_timeout", k);
      req = 4'b0000;
      repeat (3) @(negedge clk);

      // slow slave: ACK after 3 wait cycles
      ack_delay = 3;
      ready_after = 2;
      req_data[31:24] = 8'h3C;
      push_byte(3, 8'h3C, 1'b0, 3);
      req = 4'b1000;
      wait_done(300, "slow_ack", k);
      req = 4'b0000;
      repeat (3) @(negedge clk);
      ack_delay = 0;

      // reset in the middle of polling
      never_ready = 1'b1;
      exp_wr.push_back({3'd2, 8'h11});
      exp_wr.push_back({3'd0, 8'h01});
      req = 4'b0001;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!(bus.M_WB_STBo && !bus.M_WB_WEo) && k < 100);
      chk("poll_reached", bus.M_WB_STBo && !bus.M_WB_WEo, 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_cyc", bus.M_WB_CYCo, 0);
      chk("mid_rst_stb", bus.M_WB_STBo, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      req = 4'b0000;
      never_ready = 1'b0;
      init_seq();
      repeat (20) @(negedge clk);
      chk("no_stale_done", exp_done.size(), 0);
      chk("no_stale_wr", exp_wr.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
